// File: rtl/sum_acc_if.sv
// Handshake bundle between the sum adder stage, sum_acc and the consumer of frame totals.
interface sum_acc_if #(
  parameter int WIDTH     = 4,
  parameter int ACC_WIDTH = 7
);
  logic [WIDTH:0]       data_in;
  logic                 in_valid;
  logic                 in_ready;
  logic                 clear;
  logic [ACC_WIDTH-1:0] acc_out;
  logic                 out_valid;
  logic                 out_ready;
  logic                 overflow;

  modport master (
    output data_in, in_valid, clear, out_ready,
    input  in_ready, acc_out, out_valid, overflow
  );

  modport slave (
    input  data_in, in_valid, clear, out_ready,
    output in_ready, acc_out, out_valid, overflow
  );
endinterface

// File: rtl/sum_acc.sv
// Frame accumulator for the sum adder stage: sums COUNT {c_out, sum} terms and hands the total off.
// Define SUM_ACC_SAT_EN to saturate the accumulator instead of wrapping on overflow.
module sum_acc #(
  parameter int WIDTH     = 4,
  parameter int ACC_WIDTH = 7,
  parameter int COUNT     = 5
) (
  input logic      clk,
  input logic      rst_n,
  sum_acc_if.slave bus
);
  localparam int CNT_W = (COUNT > 1) ? $clog2(COUNT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(COUNT - 1);

  localparam logic [0:0] ST_ACC  = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  logic [0:0]           state;
  logic [CNT_W-1:0]     cnt;
  logic [ACC_WIDTH-1:0] acc;
  logic                 out_valid_q;
  logic                 overflow_q;
  logic                 accept;
  logic                 carry;
  logic [ACC_WIDTH-1:0] acc_next;

  assign bus.in_ready  = rst_n & (state == ST_ACC);
  assign bus.acc_out   = acc;
  assign bus.out_valid = out_valid_q;
  assign bus.overflow  = overflow_q;
  assign accept        = bus.in_valid & bus.in_ready;

  always_comb begin
    // NOTE: every always_comb output is fully assigned up front, so no path can infer a latch.
    {carry, acc_next} = {1'b0, acc} + {{(ACC_WIDTH - WIDTH){1'b0}}, bus.data_in};
`ifdef SUM_ACC_SAT_EN
    // All-ones plus any term carries again, so a saturated frame stays pinned.
    if (carry) acc_next = '1;
`endif
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    if (!rst_n || bus.clear) begin
      state       <= ST_ACC;
      cnt         <= '0;
      acc         <= '0;
      out_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else if (state == ST_HOLD) begin
      // Total is held until the consumer takes it; the next frame starts one cycle later.
      if (bus.out_ready) begin
        state       <= ST_ACC;
        cnt         <= '0;
        acc         <= '0;
        out_valid_q <= 1'b0;
        overflow_q  <= 1'b0;
      end
    end else if (accept) begin
      acc <= acc_next;
      cnt <= cnt + 1'b1;
      if (carry) overflow_q <= 1'b1;
      if (cnt == LAST) begin
        state       <= ST_HOLD;
        out_valid_q <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_sum_acc.sv
// Self-checking bench for sum_acc: a COUNT=5 and a COUNT=1 instance share one directed stimulus stream.
module tb_sum_acc;
  localparam int WIDTH     = 4;
  localparam int ACC_WIDTH = 7;
  localparam int COUNT     = 5;
  localparam int ACC_MAX   = (1 << ACC_WIDTH) - 1;
`ifdef SUM_ACC_SAT_EN
  localparam int WRAP_TOTAL = 127;
`else
  localparam int WRAP_TOTAL = 27;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic           s_valid = 1'b0;
  logic [WIDTH:0] s_data  = '0;
  logic           s_clear = 1'b0;
  logic           s_ordy  = 1'b0;

  sum_acc_if #(.WIDTH(WIDTH), .ACC_WIDTH(ACC_WIDTH)) bus5 ();
  sum_acc_if #(.WIDTH(WIDTH), .ACC_WIDTH(ACC_WIDTH)) bus1 ();

  assign bus5.data_in   = s_data;
  assign bus5.in_valid  = s_valid;
  assign bus5.clear     = s_clear;
  assign bus5.out_ready = s_ordy;
  assign bus1.data_in   = s_data;
  assign bus1.in_valid  = s_valid;
  assign bus1.clear     = s_clear;
  assign bus1.out_ready = s_ordy;

  sum_acc #(.WIDTH(WIDTH), .ACC_WIDTH(ACC_WIDTH), .COUNT(COUNT)) dut5 (
    .clk(clk), .rst_n(rst_n), .bus(bus5));
  sum_acc #(.WIDTH(WIDTH), .ACC_WIDTH(ACC_WIDTH), .COUNT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Frame model: unbounded integer total and term count; outputs derived arithmetically.
  typedef struct {
    int total;
    int terms;
    bit pending;
  } model_t;

  model_t m [2];
  int     frame_len [2];

  function automatic model_t next_model(model_t s, int len);
    model_t n;
    n = s;
    if (!rst_n || s_clear) begin
      n = '{total: 0, terms: 0, pending: 1'b0};
    end else if (s.pending) begin
      if (s_ordy) n = '{total: 0, terms: 0, pending: 1'b0};
    end else if (s_valid) begin
      n.total   = s.total + int'(s_data);
      n.terms   = s.terms + 1;
      n.pending = (n.terms == len);
    end
    return n;
  endfunction

  function automatic int exp_acc(int total);
`ifdef SUM_ACC_SAT_EN
    return (total > ACC_MAX) ? ACC_MAX : total;
`else
    return total % (ACC_MAX + 1);
`endif
  endfunction

  initial begin
    frame_len[0] = COUNT;
    frame_len[1] = 1;
    for (int i = 0; i < 2; i++) m[i] = '{total: 0, terms: 0, pending: 1'b0};
  end

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) m[i] = next_model(m[i], frame_len[i]);
  end

  always @(negedge clk) begin
    check("m5_acc",      32'(bus5.acc_out),   32'(exp_acc(m[0].total)));
    check("m5_valid",    32'(bus5.out_valid), 32'(m[0].pending));
    check("m5_overflow", 32'(bus5.overflow),  32'(m[0].total > ACC_MAX));
    check("m5_in_ready", 32'(bus5.in_ready),  32'(rst_n && !m[0].pending));
    check("m1_acc",      32'(bus1.acc_out),   32'(exp_acc(m[1].total)));
    check("m1_valid",    32'(bus1.out_valid), 32'(m[1].pending));
    check("m1_overflow", 32'(bus1.overflow),  32'(m[1].total > ACC_MAX));
    check("m1_in_ready", 32'(bus1.in_ready),  32'(rst_n && !m[1].pending));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [WIDTH:0] d, input logic clr, input logic ordy);
    s_valid = v;
    s_data  = d;
    s_clear = clr;
    s_ordy  = ordy;
  endtask

  logic [WIDTH:0] basic [5];
  logic [7:0]     mixed [10];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    basic = '{5'd3, 5'd15, 5'd16, 5'd30, 5'd1};
    // {valid, ready, clear, data[4:0]}: gaps, out_ready while accumulating, back-to-back frames.
    mixed = '{8'b1_1_0_00100, 8'b0_1_0_11111, 8'b1_0_0_01000, 8'b0_1_0_00000,
              8'b1_1_0_10000, 8'b1_0_0_00010, 8'b1_1_0_11111, 8'b1_1_0_11111,
              8'b1_0_0_11111, 8'b0_1_0_00000};

    // Reset
    rst_n = 1'b0;
    drive(0, 0, 0, 0);
    tick(); tick();
    check("rst_acc",      32'(bus5.acc_out),   0);
    check("rst_valid",    32'(bus5.out_valid), 0);
    check("rst_overflow", 32'(bus5.overflow),  0);
    check("rst_in_ready", 32'(bus5.in_ready),  0);
    rst_n = 1'b1;
    #1;
    check("release_in_ready", 32'(bus5.in_ready), 1);

    // Basic frame: 3+15+16+30+1 = 65
    foreach (basic[i]) begin drive(1, basic[i], 0, 1); tick(); end
    check("basic_valid",    32'(bus5.out_valid), 1);
    check("basic_total",    32'(bus5.acc_out),   65);
    check("basic_overflow", 32'(bus5.overflow),  0);
    drive(0, 0, 0, 1); tick();
    check("basic_drain_valid", 32'(bus5.out_valid), 0);
    check("basic_drain_acc",   32'(bus5.acc_out),   0);

    // Overflow: 5 x 31 = 155, then backpressure while upstream keeps offering 7
    repeat (5) begin drive(1, 5'd31, 0, 0); tick(); end
    check("wrap_total",    32'(bus5.acc_out),   WRAP_TOTAL);
    check("wrap_overflow", 32'(bus5.overflow),  1);
    check("wrap_valid",    32'(bus5.out_valid), 1);
    repeat (3) begin
      drive(1, 5'd7, 0, 0); tick();
      check("bp_in_ready", 32'(bus5.in_ready),  0);
      check("bp_total",    32'(bus5.acc_out),   WRAP_TOTAL);
      check("bp_valid",    32'(bus5.out_valid), 1);
    end
    drive(1, 5'd7, 0, 1); tick();
    check("bp_release_acc",      32'(bus5.acc_out),   0);
    check("bp_release_valid",    32'(bus5.out_valid), 0);
    check("bp_release_overflow", 32'(bus5.overflow),  0);
    check("bp_release_in_ready", 32'(bus5.in_ready),  1);
    drive(1, 5'd7, 0, 0); tick();
    check("next_frame_first", 32'(bus5.acc_out), 7);

    // Clear mid-frame
    drive(0, 0, 1, 0); tick();
    check("clr_idle_acc", 32'(bus5.acc_out), 0);
    drive(1, 5'd10, 0, 0); tick();
    drive(1, 5'd20, 0, 0); tick();
    check("clr_partial", 32'(bus5.acc_out), 30);
    drive(1, 5'd5, 1, 0); tick();
    check("clr_acc",      32'(bus5.acc_out),  0);
    check("clr_in_ready", 32'(bus5.in_ready), 1);
    repeat (5) begin drive(1, 5'd1, 0, 0); tick(); end
    check("clr_refill_total", 32'(bus5.acc_out),   5);
    check("clr_refill_valid", 32'(bus5.out_valid), 1);
    drive(0, 0, 0, 1); tick();

    // Reset while holding a total of 65
    foreach (basic[i]) begin drive(1, basic[i], 0, 0); tick(); end
    check("hold_total", 32'(bus5.acc_out),   65);
    check("hold_valid", 32'(bus5.out_valid), 1);
    drive(0, 0, 0, 0);
    rst_n = 1'b0;
    tick();
    check("hold_rst_acc",      32'(bus5.acc_out),   0);
    check("hold_rst_valid",    32'(bus5.out_valid), 0);
    check("hold_rst_overflow", 32'(bus5.overflow),  0);
    check("hold_rst_in_ready", 32'(bus5.in_ready),  0);
    rst_n = 1'b1;
    #1;
    check("hold_release_in_ready", 32'(bus5.in_ready), 1);

    // COUNT=1 instance: single term completes a frame
    drive(1, 5'd9, 0, 0); tick();
    drive(0, 0, 0, 0);
    check("c1_valid",    32'(bus1.out_valid), 1);
    check("c1_total",    32'(bus1.acc_out),   9);
    check("c1_in_ready", 32'(bus1.in_ready),  0);
    check("c5_running",  32'(bus5.acc_out),   9);
    check("c5_no_valid", 32'(bus5.out_valid), 0);

    // Mixed directed vectors, checked by the model on every cycle
    foreach (mixed[i]) begin
      drive(mixed[i][7], mixed[i][4:0], mixed[i][5], mixed[i][6]);
      tick();
    end
    drive(0, 0, 0, 1); tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
